// File: rtl/bram_save_sequencer.sv
// Backup-RAM save sequencer: moves one save slot between backup RAM and SD in whole sectors,
// and writes a blank image into backup RAM on request.
module bram_save_sequencer #(
  parameter int unsigned SECT_LOG2 = 4,
  parameter int unsigned FMT_WORDS = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        bk_ena,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        format_req,
  input  logic [1:0]  slot,
  input  logic        bram_wr,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        busy,
  output logic        loading,
  output logic        dirty,
  output logic        fmt_active,
  output logic [9:0]  fmt_addr,
  output logic [15:0] fmt_data,
  output logic        fmt_we
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;
  localparam logic [1:0] StFmt  = 2'd3;

  localparam logic [9:0] FmtLast = 10'(FMT_WORDS - 1);

  logic [1:0]  state_q, state_d;
  logic        load_q, save_q, fmtreq_q, ack_q;
  logic        fmt_pend_q, fmt_pend_d;
  logic        is_load_q, is_load_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        loading_q, loading_d;
  logic        dirty_q, dirty_d;
  logic        fact_q, fact_d, fwe_q, fwe_d;
  logic [9:0]  faddr_q, faddr_d;
  logic [15:0] fdata_q, fdata_d;

  logic load_edge, save_edge, fmt_edge, ack_rise, ack_fall, sect_last;

  // Header of a freshly formatted image; the rest of backup RAM is zero.
  function automatic logic [15:0] fmt_word(input logic [9:0] idx);
    case (idx)
      10'd0:   return 16'h5548;
      10'd1:   return 16'h4D42;
      10'd2:   return 16'h8800;
      10'd3:   return 16'h8010;
      default: return 16'h0000;
    endcase
  endfunction

  assign load_edge = load_req & ~load_q;
  assign save_edge = save_req & ~save_q;
  assign fmt_edge  = format_req & ~fmtreq_q;
  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;
  assign sect_last = &lba_q[SECT_LOG2-1:0];

  always_comb begin
    state_d    = state_q;
    fmt_pend_d = fmt_pend_q | fmt_edge;
    is_load_d  = is_load_q;
    lba_d      = lba_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    loading_d  = loading_q;
    dirty_d    = dirty_q;
    fact_d     = fact_q;
    fwe_d      = fwe_q;
    faddr_d    = faddr_q;
    fdata_d    = fdata_q;

    if (bram_wr && !loading_q) dirty_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (fmt_pend_q || fmt_edge) begin
          state_d = StFmt;
          fact_d  = 1'b1;
          fwe_d   = 1'b1;
          faddr_d = 10'd0;
          fdata_d = fmt_word(10'd0);
        end else if (bk_ena && (load_edge || save_edge)) begin
          state_d   = StReq;
          lba_d     = 32'(slot) << SECT_LOG2;
          is_load_d = load_edge;
          rd_d      = load_edge;
          wr_d      = ~load_edge;
          loading_d = load_edge;
        end
      end
      StReq: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StAck;
        end
      end
      StAck: begin
        if (ack_fall) begin
          if (sect_last) begin
            state_d   = StIdle;
            loading_d = 1'b0;
            dirty_d   = 1'b0;
          end else begin
            // Low bits are not all ones here, so the increment cannot reach the slot field.
            lba_d   = lba_q + 32'd1;
            rd_d    = is_load_q;
            wr_d    = ~is_load_q;
            state_d = StReq;
          end
        end
      end
      StFmt: begin
        if (faddr_q == FmtLast) begin
          state_d    = StIdle;
          fact_d     = 1'b0;
          fwe_d      = 1'b0;
          dirty_d    = 1'b0;
          fmt_pend_d = 1'b0;
        end else begin
          faddr_d = faddr_q + 10'd1;
          fdata_d = fmt_word(faddr_q + 10'd1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      load_q     <= 1'b0;
      save_q     <= 1'b0;
      fmtreq_q   <= 1'b0;
      ack_q      <= 1'b0;
      fmt_pend_q <= 1'b0;
      is_load_q  <= 1'b0;
      lba_q      <= 32'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      loading_q  <= 1'b0;
      dirty_q    <= 1'b0;
      fact_q     <= 1'b0;
      fwe_q      <= 1'b0;
      faddr_q    <= 10'd0;
      fdata_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_req;
      save_q     <= save_req;
      fmtreq_q   <= format_req;
      ack_q      <= sd_ack;
      fmt_pend_q <= fmt_pend_d;
      is_load_q  <= is_load_d;
      lba_q      <= lba_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      loading_q  <= loading_d;
      dirty_q    <= dirty_d;
      fact_q     <= fact_d;
      fwe_q      <= fwe_d;
      faddr_q    <= faddr_d;
      fdata_q    <= fdata_d;
    end
  end

  assign sd_lba     = lba_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign busy       = (state_q != StIdle);
  assign loading    = loading_q;
  assign dirty      = dirty_q;
  assign fmt_active = fact_q;
  assign fmt_addr   = faddr_q;
  assign fmt_data   = fdata_q;
  assign fmt_we     = fwe_q;

endmodule

// File: tb/tb_bram_save_sequencer.sv
// Scoreboard bench for bram_save_sequencer: an HPS model acks sector requests, a monitor
// checks every request and format strobe against expectations queued by the stimulus.
module tb_bram_save_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n, bk_ena, load_req, save_req, format_req, bram_wr;
  logic        sd_ack = 1'b0;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, busy, loading, dirty, fmt_active, fmt_we;
  logic [9:0]  fmt_addr;
  logic [15:0] fmt_data;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        ld;
    logic [31:0] lba;
  } req_t;

  req_t        req_q[$];
  logic [25:0] fmt_q[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          hps_delay = 2;

  always #5 clk_sys = ~clk_sys;

  bram_save_sequencer dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bk_ena     (bk_ena),
    .load_req   (load_req),
    .save_req   (save_req),
    .format_req (format_req),
    .slot       (slot),
    .bram_wr    (bram_wr),
    .sd_ack     (sd_ack),
    .sd_lba     (sd_lba),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .busy       (busy),
    .loading    (loading),
    .dirty      (dirty),
    .fmt_active (fmt_active),
    .fmt_addr   (fmt_addr),
    .fmt_data   (fmt_data),
    .fmt_we     (fmt_we)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return busy;
      1:       return fmt_active;
      default: return loading;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget, input string name);
    int n = 0;
    while (sig(sel) !== val && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    n_total++;
    if (sig(sel) !== val) begin
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, got %0b required %0b", name, budget, sig(sel),
               val);
    end
  endtask

  task automatic push_reqs(input logic is_load, input logic [31:0] base, input int count);
    for (int i = 0; i < count; i++)
      req_q.push_back('{rd: is_load, wr: ~is_load, ld: is_load, lba: base + 32'(i)});
  endtask

  // HPS: once a request is seen, wait hps_delay cycles then pulse sd_ack for two cycles.
  initial begin
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !sd_ack) begin
        repeat (hps_delay) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  // Monitor: each new sector request and each format strobe consumes one expectation.
  initial begin
    req_t        e;
    logic [25:0] f;
    logic        prev_req = 1'b0;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !prev_req) begin
        if (req_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_request: got rd=%0b wr=%0b lba=%0h required none", sd_rd,
                   sd_wr, sd_lba);
        end else begin
          e = req_q.pop_front();
          check("req_rd", 32'(sd_rd), 32'(e.rd));
          check("req_wr", 32'(sd_wr), 32'(e.wr));
          check("req_loading", 32'(loading), 32'(e.ld));
          check("req_lba", sd_lba, e.lba);
        end
      end
      prev_req = sd_rd || sd_wr;
      if (fmt_we || fmt_active) check("fmt_we_vs_active", 32'(fmt_we), 32'(fmt_active));
      if (fmt_we) begin
        if (fmt_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_fmt_we: got addr=%0h required none", fmt_addr);
        end else begin
          f = fmt_q.pop_front();
          check("fmt_addr", 32'(fmt_addr), 32'(f[25:16]));
          check("fmt_data", 32'(fmt_data), 32'(f[15:0]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [15:0] d;
    reset_n = 1'b0; bk_ena = 1'b1; load_req = 1'b0; save_req = 1'b0; format_req = 1'b0;
    slot = 2'd0; bram_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_wr", 32'({sd_rd, sd_wr}), 32'd0);
    check("rst_loading_dirty", 32'({loading, dirty}), 32'd0);
    check("rst_fmt_flags", 32'({fmt_active, fmt_we}), 32'd0);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_fmt_addr_data", {6'd0, fmt_addr, fmt_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Load slot 2; a core write during the load must not mark the RAM dirty.
    slot = 2'd2;
    push_reqs(1'b1, 32'h20, 16);
    load_req = 1'b1;
    @(negedge clk_sys);
    load_req = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    bram_wr = 1'b1;
    @(negedge clk_sys);
    bram_wr = 1'b0;
    @(negedge clk_sys);
    check("dirty_gated_by_loading", 32'(dirty), 32'd0);
    check("load_loading", 32'(loading), 32'd1);
    wait_sig(0, 1'b0, 3000, "load_done");
    check("load_end_loading", 32'(loading), 32'd0);
    check("load_end_dirty", 32'(dirty), 32'd0);
    check("load_sectors_left", 32'(req_q.size()), 32'd0);

    bram_wr = 1'b1;
    @(negedge clk_sys);
    bram_wr = 1'b0;
    check("dirty_set_idle", 32'(dirty), 32'd1);

    // Save slot 1 with a stalled HPS, then a format request arrives mid-save.
    hps_delay = 100;
    slot = 2'd1;
    push_reqs(1'b0, 32'h10, 16);
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
    repeat (50) @(negedge clk_sys);
    check("save_stall_wr", 32'(sd_wr), 32'd1);
    check("save_stall_lba", sd_lba, 32'h10);
    format_req = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      d = (i == 0) ? 16'h5548 : (i == 1) ? 16'h4D42 : (i == 2) ? 16'h8800 :
          (i == 3) ? 16'h8010 : 16'h0000;
      fmt_q.push_back({10'(i), d});
    end
    hps_delay = 2;
    @(negedge clk_sys);
    format_req = 1'b0;
    repeat (40) @(negedge clk_sys);
    check("save_stall_wr_late", 32'(sd_wr), 32'd1);
    check("save_stall_lba_late", sd_lba, 32'h10);
    check("fmt_waits_for_save", 32'(fmt_active), 32'd0);
    wait_sig(0, 1'b0, 3000, "save_done");
    check("save_end_dirty", 32'(dirty), 32'd0);
    check("save_sectors_left", 32'(req_q.size()), 32'd0);
    wait_sig(1, 1'b1, 10, "fmt_start");
    wait_sig(1, 1'b0, 2000, "fmt_done");
    check("fmt_end_busy", 32'(busy), 32'd0);
    check("fmt_end_dirty", 32'(dirty), 32'd0);
    check("fmt_words_left", 32'(fmt_q.size()), 32'd0);

    // Simultaneous load and save: load wins.
    slot = 2'd0;
    push_reqs(1'b1, 32'h00, 16);
    load_req = 1'b1;
    save_req = 1'b1;
    @(negedge clk_sys);
    check("prio_rd", 32'(sd_rd), 32'd1);
    check("prio_no_wr", 32'(sd_wr), 32'd0);
    wait_sig(0, 1'b0, 3000, "prio_done");
    load_req = 1'b0;
    save_req = 1'b0;
    @(negedge clk_sys);

    // Same edges with no image mounted are dropped, not queued.
    bk_ena = 1'b0;
    load_req = 1'b1;
    save_req = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("gated_busy", 32'(busy), 32'd0);
    check("gated_rd_wr", 32'({sd_rd, sd_wr}), 32'd0);
    bk_ena = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("gated_not_queued", 32'(busy), 32'd0);
    load_req = 1'b0;
    save_req = 1'b0;
    @(negedge clk_sys);

    // Reset at sector 5 of a load of slot 3.
    slot = 2'd3;
    push_reqs(1'b1, 32'h30, 6);
    load_req = 1'b1;
    @(negedge clk_sys);
    load_req = 1'b0;
    n = 0;
    while (!(sd_rd && sd_lba == 32'h35) && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    check("reach_sector5", sd_lba, 32'h35);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check("abort_rd", 32'(sd_rd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_loading", 32'(loading), 32'd0);
    check("abort_lba", sd_lba, 32'd0);

    // A level still high at reset release starts one load.
    slot = 2'd1;
    load_req = 1'b1;
    repeat (6) @(negedge clk_sys);
    push_reqs(1'b1, 32'h10, 16);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("release_start_busy", 32'(busy), 32'd1);
    wait_sig(0, 1'b0, 3000, "release_load_done");
    load_req = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("final_req_queue", 32'(req_q.size()), 32'd0);
    check("final_fmt_queue", 32'(fmt_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
